// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage that sits in front of control_unit. It holds the program
// counter, fetches words from instruction memory over a req/ack handshake,
// buffers them in a small FIFO and hands them to decode with valid/ready.
// op/func are sliced from the FIFO head so they can feed control_unit directly.
// A branch/jump redirect flushes the FIFO and restarts fetching at the target.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   defined   -> fetch_count counts words delivered to decode and saturates
//                at 32'hFFFF_FFFF; it is cleared only by reset.
//   undefined -> fetch_count is tied to zero and no counter flops exist.
//
// Ports
//   clk          in   1       system clock, rising edge
//   rst_n        in   1       asynchronous active-low reset
//   imem_req     out  1       fetch request, held until imem_ack
//   imem_addr    out  ADDR_W  fetch address, stable while imem_req is high
//   imem_ack     in   1       request accepted, imem_rdata valid this cycle
//   imem_rdata   in   DATA_W  fetched word
//   redirect     in   1       branch/jump taken: flush and restart
//   redirect_pc  in   ADDR_W  new PC (bits [1:0] ignored)
//   instr_valid  out  1       FIFO head valid
//   instr_ready  in   1       decode accepts the head this cycle
//   instr        out  DATA_W  FIFO head word (0 when empty)
//   instr_pc     out  ADDR_W  PC of FIFO head (0 when empty)
//   op           out  6       instr[31:26]
//   func         out  6       instr[5:0]
//   fetch_count  out  32      words delivered to decode
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter int                BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [5:0]        op,
    output logic [5:0]        func,
    output logic [31:0]       fetch_count
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] drop_addr_q, drop_addr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] mem_pc_q   [BUF_DEPTH];
    logic [ADDR_W-1:0] mem_pc_d   [BUF_DEPTH];
    logic [DATA_W-1:0] mem_data_q [BUF_DEPTH];
    logic [DATA_W-1:0] mem_data_d [BUF_DEPTH];

    logic              pop_s;
    logic              push_s;
    logic [CNT_W-1:0]  cnt_after_pop_s;
    logic [CNT_W-1:0]  cnt_after_push_s;
    logic [ADDR_W-1:0] redirect_tgt_s;
    logic [ADDR_W-1:0] pc_plus4_s;
    logic              unused_redirect_lsb_s;

    // Handshake decode and FIFO occupancy arithmetic shared by the FSM and FIFO.
    always_comb begin
        pop_s            = (count_q != {CNT_W{1'b0}}) && instr_ready;
        // Data is only kept from a live request that is not being redirected away.
        push_s           = (state_q == ST_REQ) && imem_ack && !redirect;
        cnt_after_pop_s  = count_q - {{PTR_W{1'b0}}, pop_s};
        cnt_after_push_s = cnt_after_pop_s + {{PTR_W{1'b0}}, push_s};
        redirect_tgt_s   = {redirect_pc[ADDR_W-1:2], 2'b00};
        pc_plus4_s       = pc_q + {{(ADDR_W-3){1'b0}}, 3'd4};
    end

    assign unused_redirect_lsb_s = ^redirect_pc[1:0];

    // Fetch FSM next state, PC update and the address held during a drop.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        if (redirect) begin
            pc_d = redirect_tgt_s;
            case (state_q)
                ST_REQ: begin
                    if (imem_ack) begin
                        state_d = ST_REQ;
                    end else begin
                        // The request is still outstanding at the old address;
                        // keep presenting it and throw its data away later.
                        state_d     = ST_DROP;
                        drop_addr_d = pc_q;
                    end
                end
                ST_DROP: begin
                    if (imem_ack) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
                ST_IDLE: state_d = ST_REQ;
                default: state_d = ST_REQ;
            endcase
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cnt_after_pop_s < DEPTH_C) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        pc_d = pc_plus4_s;
                        if (cnt_after_push_s < DEPTH_C) begin
                            state_d = ST_REQ;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_DROP: begin
                    // pc already holds the redirect target; FIFO is empty here.
                    if (imem_ack) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FIFO pointers, occupancy and storage next state; redirect flushes everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            mem_pc_d[i]   = mem_pc_q[i];
            mem_data_d[i] = mem_data_q[i];
        end
        if (redirect) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_pc_d[wr_ptr_q]   = pc_q;
                mem_data_d[wr_ptr_q] = imem_rdata;
                wr_ptr_d             = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = cnt_after_push_s;
        end
    end

    // State, PC and FIFO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            drop_addr_q <= {ADDR_W{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_pc_q[i]   <= {ADDR_W{1'b0}};
                mem_data_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_pc_q[i]   <= mem_pc_d[i];
                mem_data_q[i] <= mem_data_d[i];
            end
        end
    end

    // Outputs decoded directly from registers.
    always_comb begin
        imem_req    = (state_q == ST_REQ) || (state_q == ST_DROP);
        imem_addr   = (state_q == ST_DROP) ? drop_addr_q : pc_q;
        instr_valid = (count_q != {CNT_W{1'b0}});
        if (count_q != {CNT_W{1'b0}}) begin
            instr    = mem_data_q[rd_ptr_q];
            instr_pc = mem_pc_q[rd_ptr_q];
        end else begin
            instr    = {DATA_W{1'b0}};
            instr_pc = {ADDR_W{1'b0}};
        end
        op   = instr[31:26];
        func = instr[5:0];
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    // Delivered-word counter; a pop in a redirect cycle still counts.
    always_comb begin
        if (pop_s && (fetch_count_q != 32'hFFFF_FFFF)) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end else begin
            fetch_count_d = fetch_count_q;
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q <= 32'h0000_0000;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`else
    assign fetch_count = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Drives instr_fetch_unit with directed sequences followed by randomized imem
// latency, decode back-pressure and redirects. A transaction-level model
// (a PC, a queue of {pc,data} entries and an outstanding-request record)
// predicts every output each cycle; a few literal expectations pin the model.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [DW-1:0] imem_rdata;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic [5:0]    op;
    logic [5:0]    func;
    logic [31:0]   fetch_count;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .RESET_PC (RPC),
        .BUF_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .op         (op),
        .func       (func),
        .fetch_count(fetch_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    // Reference model state
    ent_t        q[$];
    logic [31:0] m_pc;
    logic [31:0] m_req_addr;
    bit          m_busy;      // a request is presented next cycle
    bit          m_discard;   // the outstanding request is stale
    logic [31:0] m_fcount;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h0000_0020;
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc       = RPC;
        m_req_addr = 32'h0;
        m_busy     = 1'b0;
        m_discard  = 1'b0;
        m_fcount   = 32'h0;
    endtask

    task automatic check_model();
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_fc;
        e_instr = (q.size() != 0) ? q[0].data : 32'h0;
        e_pc    = (q.size() != 0) ? q[0].pc   : 32'h0;
`ifdef FETCH_PERF_CNT_EN
        e_fc = m_fcount;
`else
        e_fc = 32'h0;
`endif
        chk("imem_req", {31'd0, imem_req}, {31'd0, m_busy});
        if (m_busy) chk("imem_addr", imem_addr, m_req_addr);
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, (q.size() != 0)});
        chk("instr", instr, e_instr);
        chk("instr_pc", instr_pc, e_pc);
        chk("op", {26'd0, op}, {26'd0, e_instr[31:26]});
        chk("func", {26'd0, func}, {26'd0, e_instr[5:0]});
        chk("fetch_count", fetch_count, e_fc);
    endtask

    // One clock: compare, drive this cycle's inputs, advance the model, then
    // return 1 time unit after the rising edge.
    task automatic step(input bit ack_en, input bit redir, input logic [31:0] rpc, input bit rdy);
        bit   ack;
        bit   pop;
        ent_t e;
        check_model();
        ack         = m_busy && ack_en;
        imem_ack    = ack;
        imem_rdata  = memfn(m_req_addr);
        redirect    = redir;
        redirect_pc = rpc;
        instr_ready = rdy;

        pop = (q.size() != 0) && rdy;
        if (pop && (m_fcount != 32'hFFFF_FFFF)) m_fcount = m_fcount + 32'd1;
        if (redir) begin
            q.delete();
            m_pc = {rpc[31:2], 2'b00};
            if (m_busy && !ack) begin
                m_discard = 1'b1;
            end else begin
                m_busy     = 1'b1;
                m_discard  = 1'b0;
                m_req_addr = m_pc;
            end
        end else begin
            if (pop) void'(q.pop_front());
            if (m_busy && ack) begin
                if (m_discard) begin
                    m_discard  = 1'b0;
                    m_req_addr = m_pc;
                end else begin
                    e.pc   = m_req_addr;
                    e.data = memfn(m_req_addr);
                    q.push_back(e);
                    m_pc       = m_pc + 32'd4;
                    m_busy     = (q.size() < DEPTH);
                    m_req_addr = m_pc;
                end
            end else if (!m_busy) begin
                m_busy     = (q.size() < DEPTH);
                m_req_addr = m_pc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic mid_reset_check(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_req_async"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_valid_async"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_instr_async"}, instr, 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ack_en;
        bit          rdy;
        bit          redir;
        logic [31:0] rpc;

        // Zero-wait imem with decode always ready: one word per cycle
        do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("t1_req", {31'd0, imem_req}, 32'd1);
        chk("t1_addr0", imem_addr, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("t1_valid", {31'd0, instr_valid}, 32'd1);
        chk("t1_instr", instr, 32'h0000_0020);
        chk("t1_op", {26'd0, op}, 32'h00);
        chk("t1_func", {26'd0, func}, 32'h20);
        chk("t1_addr4", imem_addr, 32'h4);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("t1_pc8", instr_pc, 32'h8);
        chk("t1_addrC", imem_addr, 32'hC);

        // Decode stalled: two words accepted, then the request stops
        do_reset();
        repeat (5) step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("t2_req_low", {31'd0, imem_req}, 32'd0);
        chk("t2_head0", instr_pc, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("t2_req_resume", {31'd0, imem_req}, 32'd1);
        chk("t2_addr8", imem_addr, 32'h8);
        chk("t2_head4", instr_pc, 32'h4);

        // Slow imem with a redirect during the wait
        do_reset();
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("t3_addr8", imem_addr, 32'h8);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h100, 1'b1);
        chk("t3_drop_req", {31'd0, imem_req}, 32'd1);
        chk("t3_drop_addr", imem_addr, 32'h8);
        chk("t3_flushed", {31'd0, instr_valid}, 32'd0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("t3_no_stale", {31'd0, instr_valid}, 32'd0);
        chk("t3_addr100", imem_addr, 32'h100);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("t3_head100", instr_pc, 32'h100);

        // Redirect with ack and pop in the same cycle
        step(1'b1, 1'b1, 32'h203, 1'b1);
        chk("t4_empty", {31'd0, instr_valid}, 32'd0);
        chk("t4_addr200", imem_addr, 32'h200);
`ifdef FETCH_PERF_CNT_EN
        chk("t4_fcount", fetch_count, 32'd3);
`else
        chk("t4_fcount", fetch_count, 32'd0);
`endif
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("t4_head200", instr_pc, 32'h200);

        // PC wrap at the top of the address space
        step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
        chk("t5_addr_f8", imem_addr, 32'hFFFF_FFF8);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("t5_addr_fc", imem_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("t5_addr_0", imem_addr, 32'h0);
        chk("t5_head_fc", instr_pc, 32'hFFFF_FFFC);

        // Reset asserted while a request is in flight
        mid_reset_check("t6");

        // Randomized latency, back-pressure and redirects
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                mid_reset_check("rnd");
                do_reset();
            end
            ack_en = ($urandom_range(0, 3) != 0);
            if ((c / 200) % 3 == 1) rdy = ($urandom_range(0, 3) == 0);
            else                    rdy = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else                           rpc = $urandom;
            step(ack_en, redir, rpc, rdy);
        end
        check_model();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
